// File: rtl/cla_pkg.sv
// cla_pkg: shared sizes and the registered G/P bundle of the first CLA stage
package cla_pkg;
  localparam int WIDTH = 32;
  localparam int GROUP_W = 8;
  localparam int N_GROUPS = 4;
  typedef struct packed {
    logic                c0;
    logic                sub;
    logic [N_GROUPS-1:0] gg;
    logic [N_GROUPS-1:0] gp;
    logic [WIDTH-1:0]    g;
    logic [WIDTH-1:0]    p;
  } gp_bundle_t;
endpackage

// File: rtl/cla_group_gp.sv
// cla_group_gp: group generate/propagate over one GROUP_W-bit slice
module cla_group_gp
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] i_g,
  input  logic [GROUP_W-1:0] i_p,
  output logic               o_gg,
  output logic               o_gp
);
  // ripple the generate from bit 0 upward so the top bit's term dominates
  always_comb begin
    o_gg = 1'b0;
    for (int i = 0; i < GROUP_W; i++) o_gg = i_g[i] | (i_p[i] & o_gg);
  end
  assign o_gp = &i_p;
endmodule

// File: rtl/cla_gp_pipe_stage.sv
// cla_gp_pipe_stage: registered bit/group G-P stage with a 2-entry skid buffer
module cla_gp_pipe_stage
  import cla_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic                in_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_c0,
  output logic [N_GROUPS-1:0] out_gg,
  output logic [N_GROUPS-1:0] out_gp,
  output logic [WIDTH-1:0]    out_g,
  output logic [WIDTH-1:0]    out_p,
  output logic                out_sub
);
  logic [WIDTH-1:0]    w_b, w_g, w_p;
  logic [N_GROUPS-1:0] w_gg, w_gp;
  gp_bundle_t          w_in, r_m, r_s;
  logic                r_m_v, r_s_v, w_in_xfer, w_m_load;
  assign w_b = in_sub ? ~in_b : in_b;
  assign w_g = in_a & w_b;
  assign w_p = in_a ^ w_b;
  genvar k;
  generate
    for (k = 0; k < N_GROUPS; k++) begin : g_grp
      cla_group_gp u_grp (
        .i_g  (w_g[k*GROUP_W +: GROUP_W]),
        .i_p  (w_p[k*GROUP_W +: GROUP_W]),
        .o_gg (w_gg[k]),
        .o_gp (w_gp[k])
      );
    end
  endgenerate
  assign w_in      = '{c0: in_sub, sub: in_sub, gg: w_gg, gp: w_gp, g: w_g, p: w_p};
  assign w_in_xfer = in_valid & ~r_s_v;
  assign w_m_load  = ~r_m_v | out_ready;
  // main register: refill from skid first so FIFO order is kept, else from input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m   <= '0;
      r_m_v <= 1'b0;
    end else if (w_m_load) begin
      r_m_v <= r_s_v | w_in_xfer;
      if (r_s_v) r_m <= r_s;
      else if (w_in_xfer) r_m <= w_in;
    end
  end
  // skid register: catches the input while main is stalled, drains when main frees
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s   <= '0;
      r_s_v <= 1'b0;
    end else if (w_m_load) begin
      r_s_v <= 1'b0;
    end else if (w_in_xfer) begin
      r_s   <= w_in;
      r_s_v <= 1'b1;
    end
  end
  assign in_ready  = ~r_s_v;
  assign out_valid = r_m_v;
  assign out_c0    = r_m.c0;
  assign out_sub   = r_m.sub;
  assign out_gg    = r_m.gg;
  assign out_gp    = r_m.gp;
  assign out_g     = r_m.g;
  assign out_p     = r_m.p;
endmodule

// File: doc/cla_gp_pipe_stage.md
Name: cla_gp_pipe_stage

Overview:
- Registered first-level stage of the 32-bit pipelined CLA adder/subtractor.
- Accepts operands and an add/sub select over a valid/ready handshake.
- Forms bit-level generate/propagate and per-8-bit-group generate/propagate, then presents them with carry-in c0 to the second-level lookahead carry block.
- Decouples the upstream operand source from downstream stall with a 2-entry skid buffer.

Parameters:
- WIDTH, 32, operand width; must equal N_GROUPS*GROUP_W.
- GROUP_W, 8, bits per lookahead group.
- N_GROUPS, 4, group count; fixed at 4 to match the second-level block.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  stage can accept; registered.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  1 = A-B, 0 = A+B.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  downstream accepts.
- out_c0  out  1  carry-in to the lookahead (= sub).
- out_gg  out  N_GROUPS  group generate G[3:0].
- out_gp  out  N_GROUPS  group propagate P[3:0].
- out_g  out  WIDTH  bit generate a&b'.
- out_p  out  WIDTH  bit propagate a^b'.
- out_sub  out  1  forwarded op select.

Behaviour:
- Operand preparation: b' = in_sub ? ~in_b : in_b; c0 = in_sub.
- Bit terms: g = a & b'; p = a ^ b'. These are computed before the register.
- Group terms for each group k (bits 8k..8k+7):
  - P_k = AND of p over the group.
  - G_k = g7 | p7g6 | p7p6g5 | ... | p7..p1g0.
  - All arithmetic is unsigned and no widening occurs.
- Transfers: an input transfer is in_valid & in_ready; an output transfer is out_valid & out_ready.
- Storage: main register M (drives the outputs) and skid register S.
- Reset (async, rst=1):
  - M.valid = 0 and S.valid = 0.
  - out_valid = 0 and in_ready = 1.
  - All data outputs = 0.
  - Reset mid-transaction drops every held entry; no partial state survives.
- Per cycle:
  - M empty, or M transferring out: M loads S if S is valid, otherwise it loads the input when an input transfer occurs.
  - M full and stalled (out_valid & ~out_ready) with an input transfer: the input goes into S.
  - S, once it has loaded into M, clears unless a new input transfer refills it in the same cycle. The in_ready rule prevents that refill.
- in_ready = ~S.valid, taken from the register. It is never combinational from out_ready.
- Latency is 1 cycle, input transfer to out_valid, with no stall. Throughput is 1 transfer per cycle.
- Ordering is strict FIFO and no entry is dropped or duplicated.
- Outputs are stable while out_valid & ~out_ready (AXI-style hold rule).
- Simultaneous in/out transfer with S empty: M is replaced and out_valid stays 1.
- S full and out_ready=1: S moves to M and in_ready rises the next cycle.

Decomposition:
- cla_pkg contains:
  - localparams WIDTH=32, GROUP_W=8, N_GROUPS=4.
  - typedef gp_bundle_t {c0, sub, gg[3:0], gp[3:0], g[31:0], p[31:0]}, used for M, S and the outputs.
- Sub-module cla_group_gp: combinational 8-bit group G/P from 8 bit g/p pairs, instantiated N_GROUPS times.
- The skid-buffer control stays inline.

Test Plan:
- a=0x000000FF, b=0x00000001, sub=0, out_ready=1 -> one cycle later: out_g=0x00000001, out_p=0x000000FE, out_gg=4'b0001, out_gp=4'b0000, out_c0=0.
- a=0xFFFFFFFF, b=0, sub=0 -> out_p=0xFFFFFFFF, out_g=0, out_gp=4'b1111, out_gg=4'b0000. Fed to the second-level block, this gives c32=0.
- a=5, b=5, sub=1 -> out_p=0xFFFFFFFF, out_g=0, out_gp=4'b1111, out_gg=0, out_c0=1. The downstream c32 is 1, meaning no borrow.
- Backpressure: out_ready=0; send T1,T2; in_ready goes low after T2 and T3 is held upstream. Raise out_ready -> T1, T2, T3 emerge in order on consecutive cycles, with outputs stable while stalled.
- Streaming: in_valid=out_ready=1 for 16 random operand pairs -> out_valid is continuous after 1 cycle. Every bundle matches the reference model, with no bubbles or duplicates.
- Assert rst asynchronously with M and S full -> out_valid=0, in_ready=1 and data=0 immediately (before the next clk edge). The next accepted input is emitted alone.
